// File: rtl/hs2bram_cast_pkg.sv
// Shared definitions for the handshake-to-BRAM cast: FSM state encoding and
// address-width helper.
package hs2bram_cast_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } cast_state_e;

    function automatic int addr_bits(input int range);
        return $clog2(range);
    endfunction

endpackage

// File: rtl/hs2bram_cast_if.sv
// Producer handshake and consumer BRAM read port of the cast, bundled.
// master = producer/consumer side, slave = the cast block.
interface hs2bram_cast_if #(
    parameter int IN_SIZE    = 4,
    parameter int IN_WIDTH   = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in;
    logic                             data_in_valid;
    logic                             data_in_ready;
    logic [ADDR_WIDTH-1:0]            address0;
    logic                             ce0;
    logic [IN_WIDTH-1:0]              q0;
    logic                             out_done;
    logic                             out_release;

    modport master (
        output data_in, data_in_valid, address0, ce0, out_release,
        input  data_in_ready, q0, out_done
    );

    modport slave (
        input  data_in, data_in_valid, address0, ce0, out_release,
        output data_in_ready, q0, out_done
    );
endinterface

// File: rtl/hs2bram_cast_ram_block.sv
// Dual-port RAM: port 0 read/write with registered read data, port 1 write-only.
// Contents are not reset.
module ram_block #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int MEM_SIZE = 10
) (
    input  logic              clk,
    input  logic              ce0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] d0,
    output logic [DWIDTH-1:0] q0,
    input  logic              ce1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] d1
);
    logic [DWIDTH-1:0] mem_q [MEM_SIZE];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (ce0) begin
            if (we0) begin
                mem_q[addr0] <= d0;
            end
            q0 <= mem_q[addr0];
        end
        if (ce1 && we1) begin
            mem_q[addr1] <= d1;
        end
    end
endmodule

// File: rtl/hs2bram_cast.sv
// Handshake-to-BRAM cast: unpacks accepted vectors into RAM one element per
// cycle and flags out_done once a full frame is stored.
module hs2bram_cast
    import hs2bram_cast_pkg::*;
#(
    parameter int IN_SIZE    = 4,
    parameter int IN_WIDTH   = 8,
    parameter int ADDR_RANGE = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    hs2bram_cast_if.slave   bus
);
    localparam int EW = (IN_SIZE > 1) ? addr_bits(IN_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_RANGE - 1);
    localparam logic [EW-1:0]         ELEM_LAST = EW'(IN_SIZE - 1);

    cast_state_e                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic [EW-1:0]                    elem_q, elem_d;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] vec_q, vec_d;
    logic                             done_q, done_d;
    logic                             ready;
    logic                             we1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            addr_q  <= '0;
            elem_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            elem_q  <= elem_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        elem_d  = elem_q;
        vec_d   = vec_q;
        ready   = 1'b0;
        we1     = 1'b0;
        unique case (state_q)
            FILL: begin
                ready = 1'b1;
                if (bus.data_in_valid) begin
                    vec_d   = bus.data_in;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we1    = 1'b1;
                addr_d = addr_q + 1'b1;
                elem_d = elem_q + 1'b1;
                // Frame end wins over vector end; leftover elements are dropped.
                if (addr_q == ADDR_LAST) begin
                    state_d = FULL;
                end else if (elem_q == ELEM_LAST) begin
                    state_d = FILL;
                    elem_d  = '0;
                end
            end
            FULL: begin
                if (bus.out_release) begin
                    state_d = FILL;
                    addr_d  = '0;
                    elem_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
        done_d = (state_d == FULL);
    end

    // Gating with rst keeps ready low while reset is held, even though state is FILL.
    assign bus.data_in_ready = ready & rst;
    assign bus.out_done      = done_q;

    ram_block #(
        .DWIDTH  (IN_WIDTH),
        .AWIDTH  (ADDR_WIDTH),
        .MEM_SIZE(ADDR_RANGE)
    ) u_ram (
        .clk  (clk),
        .ce0  (bus.ce0),
        .we0  (1'b0),
        .addr0(bus.address0),
        .d0   ('0),
        .q0   (bus.q0),
        .ce1  (we1),
        .we1  (we1),
        .addr1(addr_q),
        .d1   (vec_q[elem_q])
    );
endmodule

// File: tb/tb_hs2bram_cast.sv
// Directed bench for hs2bram_cast: a frame-level model predicts ready/done/q0
// every cycle, backed by hand-computed literal expectations.
module tb_hs2bram_cast;
    localparam int IN_SIZE    = 4;
    localparam int IN_WIDTH   = 8;
    localparam int ADDR_RANGE = 10;
    localparam int ADDR_WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hs2bram_cast_if #(.IN_SIZE(IN_SIZE), .IN_WIDTH(IN_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    hs2bram_cast #(
        .IN_SIZE   (IN_SIZE),
        .IN_WIDTH  (IN_WIDTH),
        .ADDR_RANGE(ADDR_RANGE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level model: counts stored elements and pending vector elements.
    logic [7:0] mm [ADDR_RANGE];
    logic [7:0] vec [IN_SIZE];
    int   stored;
    int   widx;
    bit   busy;
    bit   full;
    bit   qv;
    bit   rd_ok;
    logic [7:0] qexp;
    logic exp_ready;

    assign exp_ready = rst && !busy && !full;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stored = 0;
            widx   = 0;
            busy   = 0;
            full   = 0;
            qv     = 0;
        end else begin
            rd_ok = bus.ce0 && full && (int'(bus.address0) < ADDR_RANGE);
            if (rd_ok) qexp = mm[bus.address0];
            qv = rd_ok;
            if (busy) begin
                mm[stored] = vec[widx];
                stored++;
                widx++;
                if (stored == ADDR_RANGE) begin
                    full = 1;
                    busy = 0;
                end else if (widx == IN_SIZE) begin
                    busy = 0;
                end
            end else if (full) begin
                if (bus.out_release) begin
                    full   = 0;
                    stored = 0;
                end
            end else if (bus.data_in_valid) begin
                for (int k = 0; k < IN_SIZE; k++) vec[k] = bus.data_in[k];
                busy = 1;
                widx = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", {31'd0, bus.data_in_ready}, {31'd0, exp_ready});
        chk("done", {31'd0, bus.out_done}, {31'd0, full});
        if (qv) chk("q0", {24'd0, bus.q0}, {24'd0, qexp});
    end

    task automatic send(input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        bit ok = 0;
        @(negedge clk);
        bus.data_in[0]    = e0;
        bus.data_in[1]    = e1;
        bus.data_in[2]    = e2;
        bus.data_in[3]    = e3;
        bus.data_in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (exp_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.data_in_valid = 1'b0;
    endtask

    task automatic wait_full();
        bit ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (full) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("full_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input logic [7:0] lit [ADDR_RANGE]);
        @(negedge clk);
        bus.address0 = '0;
        bus.ce0      = 1'b1;
        for (int a = 0; a < ADDR_RANGE; a++) begin
            @(negedge clk);
            chk("q0_lit", {24'd0, bus.q0}, {24'd0, lit[a]});
            if (a < ADDR_RANGE - 1) bus.address0 = ADDR_WIDTH'(a + 1);
            else bus.ce0 = 1'b0;
        end
    endtask

    task automatic release_frame();
        @(negedge clk);
        bus.out_release = 1'b1;
        @(negedge clk);
        bus.out_release = 1'b0;
        chk("rel_done", {31'd0, bus.out_done}, 32'd0);
        chk("rel_ready", {31'd0, bus.data_in_ready}, 32'd1);
    endtask

    logic [7:0] lit1 [ADDR_RANGE] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    logic [7:0] lit2 [ADDR_RANGE] = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd40, 8'd41, 8'd42, 8'd43, 8'd60, 8'd61};
    logic [7:0] lit3 [ADDR_RANGE] = '{8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57, 8'd58, 8'd59};

    initial begin
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.address0      = '0;
        bus.ce0           = 1'b0;
        bus.out_release   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.data_in_ready}, 32'd0);
        chk("rst_done", {31'd0, bus.out_done}, 32'd0);
        rst = 1'b1;

        // Single vector: written over four edges, ready back afterwards.
        send(8'd1, 8'd2, 8'd3, 8'd4);
        chk("t1_busy", {31'd0, bus.data_in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t1_ready_back", {31'd0, bus.data_in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) chk("t1_model", {24'd0, mm[k]}, 32'(k + 1));

        // Two more vectors; the last one is truncated at address 9.
        send(8'd5, 8'd6, 8'd7, 8'd8);
        send(8'd9, 8'd10, 8'd11, 8'd12);
        wait_full();
        chk("t2_done", {31'd0, bus.out_done}, 32'd1);
        chk("t2_model9", {24'd0, mm[9]}, 32'd10);
        repeat (3) @(negedge clk);
        chk("t2_ready_full", {31'd0, bus.data_in_ready}, 32'd0);

        read_check(lit1);
        release_frame();

        // New frame from address 0; release during WRITE is ignored.
        send(8'd21, 8'd22, 8'd23, 8'd24);
        @(negedge clk);
        bus.out_release = 1'b1;
        @(negedge clk);
        bus.out_release = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_ready", {31'd0, bus.data_in_ready}, 32'd1);

        // Valid held with changing data: only FILL-cycle samples are taken.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int k = 0; k < IN_SIZE; k++) bus.data_in[k] = 8'(40 + 4 * i + k);
            bus.data_in_valid = 1'b1;
        end
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        chk("t5_done", {31'd0, bus.out_done}, 32'd1);
        read_check(lit2);
        release_frame();

        // Reset mid-WRITE after element 1, then a fresh frame.
        send(8'd31, 8'd32, 8'd33, 8'd34);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_ready", {31'd0, bus.data_in_ready}, 32'd0);
        chk("t6_rst_done", {31'd0, bus.out_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(8'd50, 8'd51, 8'd52, 8'd53);
        send(8'd54, 8'd55, 8'd56, 8'd57);
        send(8'd58, 8'd59, 8'd60, 8'd61);
        wait_full();
        read_check(lit3);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
